gpmc_regfile_bridge: RTL and testbench

- Parametrised successor to the single-bank GPMC bridge. Connects the AM335x GPMC (multiplexed A/D, async mode) to a register file of NUM_REGS words in the CLK_100M domain.
- All GPMC strobes and the A/D bus pass through 2-FF synchronisers, so the block is fully synchronous to CLK_100M.
- Upper NUM_RO registers are read-only status inputs; the rest are read/write control outputs, with a per-write strobe for downstream logic.

---
 rtl/gpmc_regfile_bridge.sv | 169 ++++++++++++++++
 tb/tb_gpmc_regfile_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_regfile_bridge.sv
// gpmc_regfile_bridge: AM335x GPMC (multiplexed A/D, async) to register-file bridge, fully synchronous to CLK_100M.
// Optional macro GPMC_AUTOINC_EN: post-increment the address in the data phase for single-address bursts.
module gpmc_regfile_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RO     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                 CLK_100M,
  input  logic                                 RST_N,
  inout  wire  [15:0]                          GPMC_AD,
  input  logic                                 GPMC_CSN1,
  input  logic                                 GPMC_ADVN,
  input  logic                                 GPMC_WEIN,
  input  logic                                 GPMC_OEN,
  input  logic [NUM_RO*DATA_WIDTH-1:0]         STATUS_IN,
  output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0] REGS_OUT,
  output logic                                 WR_STB,
  output logic [ADDR_WIDTH-1:0]                WR_ADDR,
  output logic                                 PROTO_ERR
);

  // state   | meaning
  // WAIT_CS | after reset: ignore bus until CSN1 seen high (drop cut transactions)
  // IDLE    | waiting for chip select with address valid
  // ADDR    | address phase, latch address on ADVN rising edge
  // DATA    | data phase, WEIN rise = write, OEN fall = read
  typedef enum logic [1:0] {WAIT_CS, IDLE, ADDR, DATA} state_t;

  localparam int NUM_RW = NUM_REGS - NUM_RO;
  localparam logic [ADDR_WIDTH:0] RW_LIM = (ADDR_WIDTH+1)'(NUM_RW);
  localparam logic [ADDR_WIDTH:0] REGS_LIM = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [15:0] DEAD_WORD = 16'hDEAD;
  localparam logic [DATA_WIDTH-1:0] DEAD_VAL = DEAD_WORD[DATA_WIDTH-1:0];

  state_t state, state_nxt;

  logic [2:0]  csn_q, advn_q, wein_q, oen_q;
  logic [15:0] ad_q1, ad_q2, ad_q3;
  logic [1:0]  settle_cnt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] mem [NUM_RW];
  logic [DATA_WIDTH-1:0] data_out, rd_word;
  logic rd_valid, err_lock;
  logic latch_addr, do_write, do_read, do_err, bus_en;

  always_ff @(posedge CLK_100M) begin
    if (!RST_N) begin
      csn_q  <= '1;
      advn_q <= '1;
      wein_q <= '1;
      oen_q  <= '1;
      ad_q1  <= '0;
      ad_q2  <= '0;
      ad_q3  <= '0;
    end else begin
      csn_q  <= {csn_q[1:0], GPMC_CSN1};
      advn_q <= {advn_q[1:0], GPMC_ADVN};
      wein_q <= {wein_q[1:0], GPMC_WEIN};
      oen_q  <= {oen_q[1:0], GPMC_OEN};
      ad_q1  <= GPMC_AD;
      ad_q2  <= ad_q1;
      ad_q3  <= ad_q2;
    end
  end

  // ad_q3 lines up with the third strobe flop: it is the bus value sampled while the strobe was still low
  logic csn_s, advn_s, wein_s, oen_s;
  logic csn_rise, advn_rise, advn_fall, wein_rise, oen_fall, oen_rise;
  assign csn_s     = csn_q[1];
  assign advn_s    = advn_q[1];
  assign wein_s    = wein_q[1];
  assign oen_s     = oen_q[1];
  assign csn_rise  = csn_q[1] & ~csn_q[2];
  assign advn_rise = advn_q[1] & ~advn_q[2];
  assign advn_fall = ~advn_q[1] & advn_q[2];
  assign wein_rise = wein_q[1] & ~wein_q[2];
  assign oen_fall  = ~oen_q[1] & oen_q[2];
  assign oen_rise  = oen_q[1] & ~oen_q[2];

  always_ff @(posedge CLK_100M) begin
    if (!RST_N) state <= WAIT_CS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    do_err     = 1'b0;
    case (state)
      WAIT_CS: if (settle_cnt == 2'd0 && csn_s) state_nxt = IDLE;
      IDLE:    if (!csn_s && !advn_s) state_nxt = ADDR;
      ADDR: begin
        if (csn_rise) state_nxt = IDLE;
        else if (advn_rise) begin
          latch_addr = 1'b1;
          state_nxt  = DATA;
        end
      end
      DATA: begin
        do_err   = !wein_s && !oen_s && !err_lock;
        do_write = wein_rise && !err_lock;
        do_read  = oen_fall;
        if (csn_rise) state_nxt = IDLE;
        else if (advn_fall && !csn_s) state_nxt = ADDR;
      end
      default: state_nxt = WAIT_CS;
    endcase
  end

  always_comb begin
    rd_word = DEAD_VAL;
    for (int i = 0; i < NUM_RW; i++)
      if (addr == ADDR_WIDTH'(i)) rd_word = mem[i];
    for (int k = 0; k < NUM_RO; k++)
      if (addr == ADDR_WIDTH'(NUM_RW + k)) rd_word = STATUS_IN[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge CLK_100M) begin
    if (!RST_N) begin
      settle_cnt <= 2'd2;
      addr       <= '0;
      for (int i = 0; i < NUM_RW; i++) mem[i] <= RESET_VAL;
      WR_STB     <= 1'b0;
      WR_ADDR    <= '0;
      PROTO_ERR  <= 1'b0;
      data_out   <= '0;
      rd_valid   <= 1'b0;
      err_lock   <= 1'b0;
    end else begin
      WR_STB    <= 1'b0;
      PROTO_ERR <= do_err;
      if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;

      if (latch_addr) addr <= ad_q3[ADDR_WIDTH-1:0];
`ifdef GPMC_AUTOINC_EN
      else if (do_write || (state == DATA && oen_rise)) addr <= addr + 1'b1;
`endif

      if (do_write && ({1'b0, addr} < RW_LIM)) begin
        for (int i = 0; i < NUM_RW; i++)
          if (addr == ADDR_WIDTH'(i)) mem[i] <= ad_q3[DATA_WIDTH-1:0];
        WR_STB  <= 1'b1;
        WR_ADDR <= addr;
      end

      if (do_read) data_out <= ({1'b0, addr} < REGS_LIM) ? rd_word : DEAD_VAL;

      if (oen_rise || state_nxt != DATA) rd_valid <= 1'b0;
      else if (do_read)                  rd_valid <= 1'b1;

      // Once both strobes overlap, stay locked until both are released
      if (state != DATA || (wein_s && oen_s)) err_lock <= 1'b0;
      else if (do_err)                        err_lock <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RW; i++) begin : g_out
    assign REGS_OUT[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

  assign bus_en  = (state == DATA) && !csn_s && !oen_s && wein_s && rd_valid && !err_lock;
  assign GPMC_AD = bus_en ? 16'(data_out) : {16{1'bz}};

endmodule

// File: tb/tb_gpmc_regfile_bridge.sv
// tb_gpmc_regfile_bridge: directed GPMC bus transactions against gpmc_regfile_bridge (NUM_REGS=12, NUM_RO=2).
// A pull-up on the bus makes a released (Z) bus read as 16'hFFFF.
module tb_gpmc_regfile_bridge;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NUM_REGS = 12;
  localparam int NUM_RO = 2;
  localparam logic [15:0] BUS_Z = 16'hFFFF;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_n, csn, advn, wein, oen, tb_drv;
  logic [15:0] tb_ad;
  tri1 [15:0] gpmc_ad;
  assign gpmc_ad = tb_drv ? tb_ad : {16{1'bz}};

  logic [NUM_RO*DW-1:0] status_in;
  logic [(NUM_REGS-NUM_RO)*DW-1:0] regs_out;
  logic wr_stb, proto_err;
  logic [AW-1:0] wr_addr;

  gpmc_regfile_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NUM_REGS), .NUM_RO(NUM_RO), .RESET_VAL('0)
  ) dut (
    .CLK_100M(clk_sys), .RST_N(rst_n), .GPMC_AD(gpmc_ad),
    .GPMC_CSN1(csn), .GPMC_ADVN(advn), .GPMC_WEIN(wein), .GPMC_OEN(oen),
    .STATUS_IN(status_in), .REGS_OUT(regs_out),
    .WR_STB(wr_stb), .WR_ADDR(wr_addr), .PROTO_ERR(proto_err)
  );

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  logic [AW-1:0] stb_addr = '0;

  always @(posedge clk_sys) begin
    if (wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= wr_addr;
    end
    if (proto_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reg_w(input int i);
    return regs_out[i*DW +: DW];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic addr_phase(input logic [15:0] a);
    csn = 1'b0; advn = 1'b0; tb_ad = a; tb_drv = 1'b1;
    cyc(4);
    advn = 1'b1;
    cyc(4);
    tb_drv = 1'b0;
  endtask

  // returns 3 cycles after WEIN rises, data still driven
  task automatic write_data(input logic [15:0] d);
    tb_ad = d; tb_drv = 1'b1; wein = 1'b0;
    cyc(4);
    wein = 1'b1;
    cyc(3);
  endtask

  task automatic read_data(output logic [15:0] d, output logic [15:0] after);
    tb_drv = 1'b0; oen = 1'b0;
    cyc(4);
    d = gpmc_ad;
    cyc(2);
    oen = 1'b1;
    cyc(4);
    after = gpmc_ad;
  endtask

  task automatic end_cycle();
    tb_drv = 1'b0; csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1;
    cyc(4);
  endtask

  logic [15:0] rd, rz;
  int stb_before;

  initial begin
    status_in = {16'h0A5A, 16'h1357};
    csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1; tb_drv = 1'b0; tb_ad = '0;
    rst_n = 1'b0;
    cyc(5);
    check("rst_regs0", reg_w(0), 16'h0000);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_bus_z", gpmc_ad, BUS_Z);
    rst_n = 1'b1;
    cyc(5);

    addr_phase(16'h0000);
    write_data(16'h1234);
    check("wr0_latency3", reg_w(0), 16'h1234);
    end_cycle();
    check("wr0_stb_cnt", stb_cnt, 1);
    check("wr0_stb_addr", stb_addr, 4'h0);

    addr_phase(16'h0003);
    write_data(16'hBEEF);
    end_cycle();
    check("wr3_regs", reg_w(3), 16'hBEEF);
    check("wr3_wr_addr", wr_addr, 4'h3);
    check("wr3_stb_cnt", stb_cnt, 2);
    addr_phase(16'h0003);
    read_data(rd, rz);
    end_cycle();
    check("rd3_data", rd, 16'hBEEF);
    check("rd3_released", rz, BUS_Z);

    addr_phase(16'h000B);
    read_data(rd, rz);
    end_cycle();
    check("rd_status1", rd, 16'h0A5A);
    addr_phase(16'h000A);
    read_data(rd, rz);
    end_cycle();
    check("rd_status0", rd, 16'h1357);
    stb_before = stb_cnt;
    addr_phase(16'h000B);
    write_data(16'hFFFF);
    end_cycle();
    check("wr_ro_no_stb", stb_cnt, stb_before);
    addr_phase(16'h000B);
    read_data(rd, rz);
    end_cycle();
    check("rd_status1_after_wr", rd, 16'h0A5A);

    addr_phase(16'h000D);
    read_data(rd, rz);
    end_cycle();
    check("rd_unimpl_dead", rd, 16'hDEAD);
    addr_phase(16'h000D);
    write_data(16'h4444);
    end_cycle();
    check("wr_unimpl_no_stb", stb_cnt, stb_before);

    addr_phase(16'h0003);
    wein = 1'b0; oen = 1'b0;
    cyc(6);
    check("proto_bus_z_both", gpmc_ad, BUS_Z);
    wein = 1'b1;
    cyc(6);
    check("proto_bus_z_oen", gpmc_ad, BUS_Z);
    oen = 1'b1;
    cyc(4);
    end_cycle();
    check("proto_err_once", err_cnt, 1);
    check("proto_no_write", reg_w(3), 16'hBEEF);
    check("proto_no_stb", stb_cnt, stb_before);

`ifdef GPMC_AUTOINC_EN
    addr_phase(16'h000F);
    write_data(16'h1111);
    write_data(16'h2222);
    write_data(16'h3333);
    end_cycle();
    check("burst_reg0", reg_w(0), 16'h2222);
    check("burst_reg1", reg_w(1), 16'h3333);
    check("burst_stb_cnt", stb_cnt, stb_before + 2);
    check("burst_last_addr", stb_addr, 4'h1);
`else
    addr_phase(16'h0005);
    write_data(16'h1111);
    write_data(16'h2222);
    end_cycle();
    check("same_addr_reg5", reg_w(5), 16'h2222);
    check("same_addr_reg6", reg_w(6), 16'h0000);
    check("same_addr_stb_cnt", stb_cnt, stb_before + 2);
    check("same_addr_stb_addr", stb_addr, 4'h5);
`endif

    addr_phase(16'h0002);
    tb_ad = 16'h7777; tb_drv = 1'b1; wein = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    wein = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    tb_drv = 1'b0;
    cyc(4);
    check("rstmid_no_commit", reg_w(2), 16'h0000);
    check("rstmid_regs_reset", reg_w(3), 16'h0000);
    check("rstmid_bus_z", gpmc_ad, BUS_Z);
    stb_before = stb_cnt;
    addr_phase(16'h0002);
    write_data(16'h7777);
    check("rstmid_cs_low_ignored", reg_w(2), 16'h0000);
    end_cycle();
    check("rstmid_cs_low_no_stb", stb_cnt, stb_before);
    addr_phase(16'h0002);
    write_data(16'h4242);
    end_cycle();
    check("rstmid_after_cs_high", reg_w(2), 16'h4242);
    check("rstmid_after_stb", stb_cnt, stb_before + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
